reg_dump_uart_tx: RTL and testbench
===================================

Name: reg_dump_uart_tx

Overview:
- Reads the CPU register-debug port by stepping `select` through the register indices and sampling `register_value`.
- Serialises each sampled value as a 3-byte UART frame group: index, value high byte, value low byte.
- Sits next to picorv32 at the FPGA top level and replaces bench-driven `select` stimulus on hardware, giving a host-visible register dump.

Parameters:
- CLKS_PER_BIT, 868: clock cycles per UART bit (100 MHz / 115200); legal range 2 and up.
- NUM_REGS, 32: number of registers scanned per dump, indices 0..NUM_REGS-1; legal range 1..32.
- SETTLE_CYCLES, 2: cycles `select` is held before `register_value` is sampled; legal range 1 and up.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to begin a dump; ignored while busy=1
- select  out  5  register index driven to the CPU debug port
- register_value  in  16  value of the selected register, combinational from the CPU
- tx  out  1  UART serial output; idle high
- busy  out  1  high from the cycle after start is accepted until the done cycle
- done  out  1  one-cycle pulse after the last stop bit of the final register

Behaviour:
- Reset (resetn=0, asynchronous): tx=1, select=0, busy=0, done=0, state=IDLE, counters=0. Reset mid-frame forces tx high immediately with no partial stop bit.
- Every cycle between bits is a whole number of CLKS_PER_BIT cycles. All outputs are registered.
- FSM states: IDLE, SETTLE, CAPTURE, SEND, NEXT, DONE.
- IDLE: tx=1. When start=1, go to SETTLE with idx=0, select=0, busy=1 on the next edge.
- SETTLE: hold select=idx for SETTLE_CYCLES cycles, then go to CAPTURE.
- CAPTURE: a single cycle. Latch shadow={8'(idx), register_value[15:8], register_value[7:0]} and set byte_cnt=0. Go to SEND. Later changes on register_value do not affect the frame.
- SEND: transmit shadow byte byte_cnt as a standard 8N1 frame:
  - start bit 0, then data bits LSB first, then one stop bit 1;
  - each bit lasts exactly CLKS_PER_BIT cycles;
  - bytes go back to back with no idle gap;
  - after byte 2's stop bit completes, go to NEXT.
- NEXT:
  - If idx==NUM_REGS-1: go to DONE.
  - Otherwise: idx+1, select updates on the same edge, go to SETTLE.
- DONE: done=1 for exactly one cycle, busy=0, select=0, then go to IDLE. A start asserted during DONE is ignored.
- Widths: idx is 5 bits. The index byte is zero-extended: {3'b000, idx}.
- start held high continuously starts a new dump on the cycle after DONE (IDLE samples it).
- Per-register time is SETTLE_CYCLES + 1 + 30*CLKS_PER_BIT cycles. A full dump is NUM_REGS times that, plus 2 cycles (IDLE accept, DONE).

Decomposition:
- Shared package reg_dump_pkg:
  - state enum;
  - UART_START=1'b0, UART_STOP=1'b1;
  - BYTES_PER_REG=3, BITS_PER_FRAME=10.
- One sub-module, uart_tx_byte:
  - inputs: clk, resetn, load, data[7:0];
  - outputs: tx, ready;
  - owns the bit-rate counter and shift register.
- The parent FSM issues one load per byte and waits for ready.

Test Plan:
1. Reset and idle: resetn=0 for 10 cycles, then released with no start → tx=1, select=0, busy=0, done=0 held for 1000 cycles.
2. Single-register dump (NUM_REGS=1, CLKS_PER_BIT=4, SETTLE_CYCLES=2), register_value=16'hA55A, start pulse → select=0 and busy rises the cycle after start.
   - Decoded bytes are 8'h00, 8'hA5, 8'h5A.
   - Each bit is 4 cycles wide; frames are back to back.
   - done pulses once, 2+1+120 cycles after busy rose.
3. Full scan (NUM_REGS=32, CLKS_PER_BIT=4), bench model returns {11'h0, select} → 96 bytes received.
   - Byte triplet k is {k, 8'h00, k} for k = 0..31.
   - select takes 0..31 in order, then returns to 0 with the done pulse.
4. Capture isolation: register_value changes from 16'h1234 to 16'hFFFF two cycles after CAPTURE → transmitted bytes are still 8'h12, 8'h34.
5. Start while busy: a second start pulse mid-dump → no restart. Exactly 3*NUM_REGS bytes and one done pulse.
6. Reset mid-frame: resetn=0 during data bit 3 of the value-high byte → tx=1 within the same cycle. busy=0, select=0; no further bytes after release until a new start.

Source files
------------

// File: rtl/reg_dump_pkg.sv
`default_nettype none
// ============================================================================
// reg_dump_pkg : shared state encoding, UART framing constants and helpers
// Revision: 1.0 - initial release
// ============================================================================
package reg_dump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SEND    = 3'd3,
    ST_NEXT    = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  localparam logic UART_START     = 1'b0;
  localparam logic UART_STOP      = 1'b1;
  localparam int   BYTES_PER_REG  = 3;
  localparam int   BITS_PER_FRAME = 10;

  // Byte n of the {index, value_hi, value_lo} shadow, index byte first.
  function automatic logic [7:0] frame_byte(input logic [23:0] shadow, input logic [1:0] n);
    logic [7:0] b;
    case (n)
      2'd0:    b = shadow[23:16];
      2'd1:    b = shadow[15:8];
      default: b = shadow[7:0];
    endcase
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// ============================================================================
// uart_tx_byte : 8N1 serialiser for a single byte, bit-rate counter + shifter
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx_byte
  import reg_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam int            BW        = $clog2(BITS_PER_FRAME);
  localparam logic [CW-1:0] LAST_CLK  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(BITS_PER_FRAME - 1);
  localparam logic [BW-1:0] STOP_PREV = BW'(BITS_PER_FRAME - 2);

  logic          active_q, active_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          bit_end;

  // ready also rises in the final stop-bit cycle so the next load starts
  // its start bit right after, giving back-to-back frames.
  always_comb begin
    bit_end   = active_q && (clk_cnt_q == LAST_CLK);
    ready     = !active_q || (bit_end && (bit_cnt_q == LAST_BIT));
    active_d  = active_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    if (load && ready) begin
      active_d  = 1'b1;
      clk_cnt_d = '0;
      bit_cnt_d = '0;
      shift_d   = data;
      tx_d      = UART_START;
    end else if (bit_end) begin
      clk_cnt_d = '0;
      if (bit_cnt_q == LAST_BIT) begin
        active_d = 1'b0;
        tx_d     = UART_STOP;
      end else begin
        bit_cnt_d = bit_cnt_q + BW'(1);
        if (bit_cnt_q < STOP_PREV) begin
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
        end else begin
          tx_d = UART_STOP;
        end
      end
    end else if (active_q) begin
      clk_cnt_d = clk_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      active_q  <= 1'b0;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= UART_STOP;
    end else begin
      active_q  <= active_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

  assign tx = tx_q;

endmodule
`default_nettype wire

// File: rtl/reg_dump_uart_tx.sv
`default_nettype none
// ============================================================================
// reg_dump_uart_tx : scans the CPU debug registers and sends each as 3 bytes
// Revision: 1.0 - initial release
// ============================================================================
module reg_dump_uart_tx
  import reg_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT  = 868,
  parameter int NUM_REGS      = 32,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  output logic [4:0]  select,
  input  logic [15:0] register_value,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int            SW          = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [4:0]    LAST_IDX    = 5'(NUM_REGS - 1);
  localparam logic [1:0]    LAST_BYTE   = 2'(BYTES_PER_REG - 1);

  state_e        state_q, state_d;
  logic [4:0]    idx_q, idx_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [23:0]   shadow_q, shadow_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          load;
  logic [7:0]    load_data;
  logic          ready;

  // The index byte is known before sampling, so it is loaded as SETTLE ends
  // and goes out during CAPTURE; this keeps the per-register time at
  // SETTLE_CYCLES + 1 + 30 bit times with NEXT overlapping the line idle.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    settle_d   = settle_q;
    shadow_d   = shadow_q;
    byte_cnt_d = byte_cnt_q;
    busy_d     = busy_q;
    done_d     = done_q;
    load       = 1'b0;
    load_data  = frame_byte(shadow_q, byte_cnt_q + 2'd1);
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_SETTLE;
          idx_d    = '0;
          settle_d = '0;
          busy_d   = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          load      = 1'b1;
          load_data = {3'b000, idx_q};
          state_d   = ST_CAPTURE;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      ST_CAPTURE: begin
        shadow_d   = {3'b000, idx_q, register_value};
        byte_cnt_d = '0;
        state_d    = ST_SEND;
      end
      ST_SEND: begin
        if (ready) begin
          if (byte_cnt_q == LAST_BYTE) begin
            state_d = ST_NEXT;
          end else begin
            load       = 1'b1;
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end
      ST_NEXT: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
          idx_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d  = ST_SETTLE;
          idx_d    = idx_q + 5'd1;
          settle_d = '0;
        end
      end
      ST_DONE: begin
        done_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      settle_q   <= '0;
      shadow_q   <= '0;
      byte_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      settle_q   <= settle_d;
      shadow_q   <= shadow_d;
      byte_cnt_q <= byte_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk   (clk),
    .resetn(resetn),
    .load  (load),
    .data  (load_data),
    .tx    (tx),
    .ready (ready)
  );

  assign select = idx_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_dump_uart_tx.sv
`default_nettype none
// ============================================================================
// tb_reg_dump_uart_tx : scoreboard bench with a timing-level dump model
// Revision: 1.0 - initial release
// ============================================================================
module tb_reg_dump_uart_tx;

  localparam int CPB    = 4;
  localparam int NREG   = 32;
  localparam int SETTLE = 2;
  localparam int T      = SETTLE + 1 + 30 * CPB;

  typedef struct {
    logic [7:0] b;
    int         cyc_at;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  select;
  logic [15:0] register_value;
  logic        tx, busy, done;

  logic [15:0] reg_file [32];
  exp_t        exp_q [$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          m_on = 1'b0;
  int          m_c0 = 0;

  reg_dump_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .NUM_REGS     (NREG),
    .SETTLE_CYCLES(SETTLE)
  ) u_dut (
    .clk           (clk),
    .resetn        (resetn),
    .start         (start),
    .select        (select),
    .register_value(register_value),
    .tx            (tx),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign register_value = reg_file[select];

  // Control-output model and start acceptance, evaluated mid-cycle.
  logic       e_busy, e_done;
  logic [4:0] e_sel;
  int         c;
  always @(negedge clk) begin
    c      = cyc;
    e_busy = 1'b0;
    e_done = 1'b0;
    e_sel  = '0;
    if (resetn && m_on && c >= m_c0 && c < m_c0 + NREG * T) begin
      e_busy = 1'b1;
      e_sel  = 5'((c - m_c0) / T);
    end else if (resetn && m_on && c == m_c0 + NREG * T) begin
      e_done = 1'b1;
    end
    checks++;
    if (busy !== e_busy || select !== e_sel || done !== e_done || (!e_busy && tx !== 1'b1)) begin
      errors++;
      $display("FAIL ctrl @%0d: busy=%b select=%0d done=%b tx=%b, expected busy=%b select=%0d done=%b%s",
               c, busy, select, done, tx, e_busy, e_sel, e_done, e_busy ? "" : " tx=1");
    end
    if (resetn && start && !(m_on && c <= m_c0 + NREG * T)) begin
      m_on = 1'b1;
      m_c0 = c + 1;
      for (int k = 0; k < NREG; k++) begin
        for (int b = 0; b < 3; b++) begin
          exp_t e;
          e.b      = (b == 0) ? 8'(k) : (b == 1) ? reg_file[k][15:8] : reg_file[k][7:0];
          e.cyc_at = m_c0 + k * T + SETTLE + b * 10 * CPB;
          exp_q.push_back(e);
        end
      end
    end
  end

  // UART line monitor: decodes frames and checks value, start time, bit widths.
  logic [9:0] bits;
  bit         unsteady, aborted;
  int         st;
  exp_t       got_e;
  initial begin
    forever begin
      @(negedge clk);
      if (resetn && tx === 1'b0) begin
        st       = cyc;
        unsteady = 1'b0;
        aborted  = 1'b0;
        for (int b = 0; b < 10; b++) begin
          for (int k = 0; k < CPB; k++) begin
            if (b != 0 || k != 0) @(negedge clk);
            if (!resetn) aborted = 1'b1;
            if (k == 0) bits[b] = tx;
            else if (tx !== bits[b]) unsteady = 1'b1;
          end
        end
        if (!aborted) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL uart_byte: unexpected byte %h starting @%0d, expected none", bits[8:1], st);
          end else begin
            got_e = exp_q.pop_front();
            if (bits[0] !== 1'b0 || bits[9] !== 1'b1 || unsteady || bits[8:1] !== got_e.b || st != got_e.cyc_at) begin
              errors++;
              $display("FAIL uart_byte: got %h @%0d (start=%b stop=%b unsteady=%b), expected %h @%0d",
                       bits[8:1], st, bits[0], bits[9], unsteady, got_e.b, got_e.cyc_at);
            end
          end
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic finish_dump(input string name);
    int n;
    n = 0;
    while (m_on && cyc <= m_c0 + NREG * T + 1 && n < 10000) begin
      tick();
      n++;
    end
    tick(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s byte_count: %0d bytes still outstanding, expected 0", name, exp_q.size());
    end
  endtask

  task automatic randomize_regs();
    for (int k = 0; k < 32; k++) reg_file[k] = 16'($urandom);
  endtask

  int old_c0, n, target;
  initial begin
    for (int k = 0; k < 32; k++) reg_file[k] = '0;
    resetn = 1'b0;
    tick(10);
    resetn = 1'b1;
    tick(1000);

    randomize_regs();
    reg_file[0] = 16'hA55A;
    pulse_start();
    finish_dump("random_a55a");

    for (int k = 0; k < 32; k++) reg_file[k] = 16'(k);
    pulse_start();
    finish_dump("index_scan");

    for (int k = 0; k < 32; k++) reg_file[k] = (k % 2 == 0) ? 16'h1234 : 16'($urandom);
    pulse_start();
    for (int k = 0; k < NREG; k++) begin
      while (cyc < m_c0 + k * T + SETTLE + 2) tick();
      reg_file[k] = 16'hFFFF;
    end
    finish_dump("capture_isolation");

    randomize_regs();
    pulse_start();
    tick(500);
    pulse_start();
    tick(1500);
    pulse_start();
    while (cyc < m_c0 + NREG * T - 3) tick();
    start  = 1'b1;
    old_c0 = m_c0;
    n      = 0;
    while (m_c0 == old_c0 && n < 100) begin
      tick();
      n++;
    end
    start = 1'b0;
    finish_dump("held_start");

    randomize_regs();
    reg_file[0] = 16'hA55A;
    pulse_start();
    target = m_c0 + SETTLE + 14 * CPB + 1;
    while (cyc < target) tick();
    checks++;
    if (tx !== 1'b0) begin
      errors++;
      $display("FAIL pre_reset_tx: tx=%b, expected 0 (bit 3 of A5)", tx);
    end
    resetn = 1'b0;
    m_on   = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || select !== 5'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_frame: tx=%b busy=%b select=%0d done=%b, expected tx=1 busy=0 select=0 done=0",
               tx, busy, select, done);
    end
    tick(3);
    resetn = 1'b1;
    tick(600);

    randomize_regs();
    pulse_start();
    finish_dump("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
